// File: rtl/dmem_seq_pkg.sv
// dmem_seq_pkg: shared types, widths and helpers for the data-memory access sequencer.
package dmem_seq_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned LANE_W  = 32;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned BEATS_W = 3;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_e;

   // Raw size field to access size; the unused encoding behaves as a word.
   function automatic size_e decode_size(input logic [1:0] raw);
      size_e sz;
      case (raw)
         2'b00:   sz = SZ_B;
         2'b01:   sz = SZ_H;
         default: sz = SZ_W;
      endcase
      return sz;
   endfunction

   // Number of byte beats needed for an access size.
   function automatic logic [BEATS_W-1:0] beats(input size_e sz);
      logic [BEATS_W-1:0] n;
      case (sz)
         SZ_B:    n = BEATS_W'(1);
         SZ_H:    n = BEATS_W'(2);
         default: n = BEATS_W'(4);
      endcase
      return n;
   endfunction

endpackage

// File: rtl/dmem_byte_lane.sv
// dmem_byte_lane: picks the store byte for a beat and places a load byte into its lane.
module dmem_byte_lane
   import dmem_seq_pkg::*;
(
   input  logic [IDX_W-1:0]  widx_i,
   input  logic [LANE_W-1:0] wdata_i,
   output logic [BYTE_W-1:0] wbyte_o,
   input  logic [IDX_W-1:0]  ridx_i,
   input  logic [BYTE_W-1:0] rbyte_i,
   output logic [LANE_W-1:0] rplace_o
);

   // Little-endian: beat k carries bits [8k+7:8k].
   assign wbyte_o  = wdata_i[{widx_i, 3'b000} +: BYTE_W];
   assign rplace_o = LANE_W'(rbyte_i) << {ridx_i, 3'b000};

endmodule

// File: rtl/dmem_access_seq.sv
// dmem_access_seq: splits MEM-stage loads/stores into byte beats on a byte-wide
// single-port data memory, assembles load data and stalls the pipeline meanwhile.
// Optional feature macro: DMEM_MISALIGN_CHK_EN (reject misaligned half/word with err_o).
module dmem_access_seq
   import dmem_seq_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              req_ready_o,
   output logic              stall_o,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_we_o,
   output logic [BYTE_W-1:0] mem_wdata_o,
   input  logic [BYTE_W-1:0] mem_rdata_i
);

   state_e              state_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BEATS_W-1:0]  beats_q;
   logic [IDX_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                ready_q;
   logic                rsp_valid_q;
   logic                err_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_we_q;
   logic [BYTE_W-1:0]   mem_wdata_q;

   size_e               req_size_d;
   logic                misalign_d;
   logic                last_beat_d;
   logic [IDX_W-1:0]    cnt_nxt_d;
   logic [IDX_W-1:0]    lane_widx_d;
   logic [LANE_W-1:0]   lane_wdata_d;
   logic [BYTE_W-1:0]   lane_wbyte_d;
   logic [LANE_W-1:0]   lane_rplace_d;

   assign req_size_d  = decode_size(req_size_i);
   assign cnt_nxt_d   = cnt_q + IDX_W'(1);
   assign last_beat_d = ({1'b0, cnt_q} == (beats_q - BEATS_W'(1)));

`ifdef DMEM_MISALIGN_CHK_EN
   // Half must be 2-byte aligned, word 4-byte aligned.
   assign misalign_d = ((req_size_d == SZ_H) && req_addr_i[0]) ||
                       ((req_size_d == SZ_W) && (req_addr_i[1:0] != 2'b00));
`else
   assign misalign_d = 1'b0;
`endif

   // On accept the first beat comes straight from the request; afterwards from the latch.
   assign lane_widx_d  = (state_q == IDLE) ? IDX_W'(0) : cnt_nxt_d;
   assign lane_wdata_d = (state_q == IDLE) ? req_wdata_i : wdata_q;

   dmem_byte_lane u_lane (
      .widx_i   (lane_widx_d),
      .wdata_i  (lane_wdata_d),
      .wbyte_o  (lane_wbyte_d),
      .ridx_i   (cnt_q),
      .rbyte_i  (mem_rdata_i),
      .rplace_o (lane_rplace_d)
   );

   // Sequencer FSM with beat counter, request latch and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         beats_q     <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  beats_q <= beats(req_size_d);
                  cnt_q   <= '0;
                  rdata_q <= '0;
                  ready_q <= 1'b0;
                  if (misalign_d) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                     err_q       <= 1'b1;
                  end else begin
                     state_q     <= BUSY;
                     mem_addr_q  <= req_addr_i;
                     mem_we_q    <= req_we_i;
                     mem_wdata_q <= lane_wbyte_d;
                  end
               end
            end
            BUSY: begin
               if (!we_q) begin
                  rdata_q <= rdata_q | lane_rplace_d;
               end
               if (last_beat_d) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  cnt_q       <= '0;
                  mem_addr_q  <= '0;
                  mem_we_q    <= 1'b0;
                  mem_wdata_q <= '0;
               end else begin
                  cnt_q       <= cnt_nxt_d;
                  mem_addr_q  <= addr_q + ADDR_W'(cnt_nxt_d);
                  mem_wdata_q <= lane_wbyte_d;
               end
            end
            RESP: begin
               state_q     <= IDLE;
               rsp_valid_q <= 1'b0;
               err_q       <= 1'b0;
               ready_q     <= 1'b1;
            end
            default: begin
               state_q <= IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Stall follows the incoming request in IDLE so the pipeline freezes on the accept cycle.
   assign stall_o     = ((state_q == IDLE) && req_valid_i) || (state_q == BUSY);
   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign err_o       = err_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_we_o    = mem_we_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_seq.sv
// tb_dmem_access_seq: scenario tasks against a byte-array memory model and a response scoreboard.
`timescale 1ns/1ps
module tb_dmem_access_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, stall, rsp_valid, err;
   logic [31:0] rsp_rdata;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata, mem_rdata;

   logic [7:0]  mem [0:255];

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] b_addr[$];
   logic [7:0]  b_wdata[$];
   logic        b_we[$];

   int          checks = 0;
   int          failures = 0;
   int          lat, stall_cnt;
   logic        got_rsp, got_err, pre_stall, post_rsp_valid;
   logic [31:0] got_rdata;
   exp_t        e;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[7:0]];

   dmem_access_seq dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_we_i    (req_we),
      .req_size_i  (req_size),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_ready_o (req_ready),
      .stall_o     (stall),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .err_o       (err),
      .mem_addr_o  (mem_addr),
      .mem_we_o    (mem_we),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // One clock: memory write happens at the edge with pre-edge values; returns at the next negedge.
   task automatic cyc();
      logic       we;
      logic [7:0] a, d;
      we = mem_we;
      a  = mem_addr[7:0];
      d  = mem_wdata;
      @(posedge clk);
      if (we && rst_n) mem[a] = d;
      @(negedge clk);
   endtask

   function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[8*k +: 8] = mem[8'(addr + 32'(k))];
      return r;
   endfunction

   // Issue one access from IDLE and record its beats and response (no checking here).
   task automatic do_access(input logic we, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd);
      b_addr.delete(); b_wdata.delete(); b_we.delete();
      got_rsp = 1'b0; got_err = 1'b0; got_rdata = '0; stall_cnt = 0;
      req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
      #1;
      pre_stall = stall;
      cyc();
      req_valid = 1'b0;
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin
            got_rsp = 1'b1; got_rdata = rsp_rdata; got_err = err;
            break;
         end
         if (stall) stall_cnt++;
         if (stall && !req_ready) begin
            b_addr.push_back(mem_addr); b_wdata.push_back(mem_wdata); b_we.push_back(mem_we);
         end
         cyc();
         lat++;
      end
      cyc();
      post_rsp_valid = rsp_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({req_ready, stall, rsp_valid, err} !== 4'b1000) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=1000", {req_ready, stall, rsp_valid, err});
      end
      checks++;
      if ({mem_addr, mem_we, mem_wdata, rsp_rdata} !== '0) begin
         failures++; $display("FAIL reset_data addr=%h we=%b wd=%h rd=%h exp=all 0",
                              mem_addr, mem_we, mem_wdata, rsp_rdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word_load();
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h22; mem[8'h02] = 8'h33; mem[8'h03] = 8'h44;
      sb.push_back('{rdata: 32'h4433_2211, err: 1'b0});
      do_access(1'b0, 2'b10, 32'h0000_0100, 32'h0);
      checks++;
      if (!got_rsp) begin failures++; $display("FAIL wl_timeout got=no rsp exp=rsp"); end
      e = sb.pop_front();
      checks++;
      if (got_rdata !== e.rdata) begin failures++; $display("FAIL wl_rdata got=%h exp=%h", got_rdata, e.rdata); end
      checks++;
      if (got_err !== e.err) begin failures++; $display("FAIL wl_err got=%b exp=%b", got_err, e.err); end
      checks++;
      if (lat !== 5) begin failures++; $display("FAIL wl_latency got=%0d exp=5", lat); end
      checks++;
      if (stall_cnt !== 4) begin failures++; $display("FAIL wl_stall got=%0d exp=4", stall_cnt); end
      checks++;
      if (pre_stall !== 1'b1) begin failures++; $display("FAIL wl_accept_stall got=%b exp=1", pre_stall); end
      checks++;
      if (b_addr.size() !== 4) begin failures++; $display("FAIL wl_beats got=%0d exp=4", b_addr.size()); end
      for (int k = 0; k < b_addr.size() && k < 4; k++) begin
         checks++;
         if (b_addr[k] !== 32'h100 + 32'(k) || b_we[k] !== 1'b0) begin
            failures++; $display("FAIL wl_beat%0d got=%h/%b exp=%h/0", k, b_addr[k], b_we[k], 32'h100 + 32'(k));
         end
      end
      checks++;
      if (post_rsp_valid !== 1'b0) begin failures++; $display("FAIL wl_pulse got=%b exp=0", post_rsp_valid); end
      cyc(); cyc();
      checks++;
      if (rsp_rdata !== 32'h4433_2211) begin failures++; $display("FAIL wl_hold got=%h exp=44332211", rsp_rdata); end
      checks++;
      if ({req_ready, mem_addr, mem_we} !== {1'b1, 32'h0, 1'b0}) begin
         failures++; $display("FAIL wl_idle ready=%b addr=%h we=%b exp=1/0/0", req_ready, mem_addr, mem_we);
      end
   endtask

   task automatic test_byte_store();
      mem[8'h07] = 8'h00; mem[8'h08] = 8'h5A;
      sb.push_back('{rdata: 32'h0, err: 1'b0});
      do_access(1'b1, 2'b00, 32'h0000_0007, 32'hAABB_CCDD);
      checks++;
      if (!got_rsp) begin failures++; $display("FAIL bs_timeout got=no rsp exp=rsp"); end
      e = sb.pop_front();
      checks++;
      if (got_rdata !== e.rdata) begin failures++; $display("FAIL bs_rdata got=%h exp=%h", got_rdata, e.rdata); end
      checks++;
      if (lat !== 2) begin failures++; $display("FAIL bs_latency got=%0d exp=2", lat); end
      checks++;
      if (b_addr.size() !== 1) begin failures++; $display("FAIL bs_beats got=%0d exp=1", b_addr.size()); end
      checks++;
      if ({b_addr[0], b_we[0], b_wdata[0]} !== {32'h7, 1'b1, 8'hDD}) begin
         failures++; $display("FAIL bs_beat got=%h/%b/%h exp=00000007/1/dd", b_addr[0], b_we[0], b_wdata[0]);
      end
      checks++;
      if ({mem[8'h07], mem[8'h08]} !== 16'hDD5A) begin
         failures++; $display("FAIL bs_mem got=%h exp=dd5a", {mem[8'h07], mem[8'h08]});
      end
   endtask

   task automatic test_wrap_half();
      mem[8'hFF] = 8'h12; mem[8'h00] = 8'h34;
`ifdef DMEM_MISALIGN_CHK_EN
      sb.push_back('{rdata: 32'h0, err: 1'b1});
`else
      sb.push_back('{rdata: model_load(32'hFFFF_FFFF, 2), err: 1'b0});
`endif
      do_access(1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0);
      checks++;
      if (!got_rsp) begin failures++; $display("FAIL wh_timeout got=no rsp exp=rsp"); end
      e = sb.pop_front();
      checks++;
      if ({got_rdata, got_err} !== {e.rdata, e.err}) begin
         failures++; $display("FAIL wh_rsp got=%h/%b exp=%h/%b", got_rdata, got_err, e.rdata, e.err);
      end
`ifdef DMEM_MISALIGN_CHK_EN
      checks++;
      if (b_addr.size() !== 0) begin failures++; $display("FAIL wh_beats got=%0d exp=0", b_addr.size()); end
`else
      checks++;
      if (b_addr.size() !== 2) begin failures++; $display("FAIL wh_beats got=%0d exp=2", b_addr.size()); end
      checks++;
      if ({b_addr[0], b_addr[1]} !== {32'hFFFF_FFFF, 32'h0}) begin
         failures++; $display("FAIL wh_wrap got=%h,%h exp=ffffffff,00000000", b_addr[0], b_addr[1]);
      end
`endif
   endtask

   task automatic test_size3();
      mem[8'h50] = 8'hA1; mem[8'h51] = 8'hB2; mem[8'h52] = 8'hC3; mem[8'h53] = 8'hD4;
      sb.push_back('{rdata: 32'hD4C3_B2A1, err: 1'b0});
      do_access(1'b0, 2'b11, 32'h0000_0050, 32'h0);
      e = sb.pop_front();
      checks++;
      if ({got_rsp, got_rdata} !== {1'b1, e.rdata}) begin
         failures++; $display("FAIL s3_rsp got=%b/%h exp=1/%h", got_rsp, got_rdata, e.rdata);
      end
      checks++;
      if (b_addr.size() !== 4 || lat !== 5) begin
         failures++; $display("FAIL s3_beats got=%0d/%0d exp=4/5", b_addr.size(), lat);
      end
   endtask

   task automatic test_back_to_back();
      int   n;
      logic ready_busy, seen;
      int   nb;
      mem[8'h20] = 8'hA0; mem[8'h21] = 8'hA1; mem[8'h22] = 8'hA2; mem[8'h23] = 8'hA3;
      mem[8'h30] = 8'hB0; mem[8'h31] = 8'hB1; mem[8'h32] = 8'hB2; mem[8'h33] = 8'hB3;
      sb.push_back('{rdata: 32'hA3A2_A1A0, err: 1'b0});
      sb.push_back('{rdata: 32'hB3B2_B1B0, err: 1'b0});
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h20; req_wdata = '0;
      cyc();
      req_addr = 32'h30;
      n = 1; ready_busy = 1'b0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin seen = 1'b1; got_rdata = rsp_rdata; break; end
         if (req_ready) ready_busy = 1'b1;
         cyc(); n++;
      end
      e = sb.pop_front();
      checks++;
      if ({seen, got_rdata} !== {1'b1, e.rdata}) begin
         failures++; $display("FAIL b2b_first got=%b/%h exp=1/%h", seen, got_rdata, e.rdata);
      end
      checks++;
      if (n !== 5 || ready_busy !== 1'b0) begin
         failures++; $display("FAIL b2b_first_lat got=%0d/ready%b exp=5/ready0", n, ready_busy);
      end
      cyc();
      checks++;
      if ({req_ready, stall} !== 2'b11) begin
         failures++; $display("FAIL b2b_idle got=%b exp=11", {req_ready, stall});
      end
      cyc();
      req_valid = 1'b0;
      n = 1; nb = 0; seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rsp_valid) begin seen = 1'b1; got_rdata = rsp_rdata; break; end
         if (stall && !req_ready) nb++;
         cyc(); n++;
      end
      e = sb.pop_front();
      checks++;
      if ({seen, got_rdata} !== {1'b1, e.rdata}) begin
         failures++; $display("FAIL b2b_second got=%b/%h exp=1/%h", seen, got_rdata, e.rdata);
      end
      checks++;
      if (n !== 5 || nb !== 4) begin
         failures++; $display("FAIL b2b_second_beats got=%0d/%0d exp=5/4", n, nb);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      logic seen;
      mem[8'h40] = 8'h00; mem[8'h41] = 8'h00; mem[8'h42] = 8'h00; mem[8'h43] = 8'h00;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'hDDCC_BBAA;
      cyc();
      req_valid = 1'b0;
      cyc(); cyc();
      checks++;
      if ({mem_addr, mem_we, mem_wdata} !== {32'h42, 1'b1, 8'hCC}) begin
         failures++; $display("FAIL rm_beat2 got=%h/%b/%h exp=00000042/1/cc", mem_addr, mem_we, mem_wdata);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({req_ready, stall, rsp_valid, err, mem_we, mem_addr} !== {5'b10000, 32'h0}) begin
         failures++; $display("FAIL rm_async got=%b/%h exp=10000/00000000",
                              {req_ready, stall, rsp_valid, err, mem_we}, mem_addr);
      end
      checks++;
      if ({mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]} !== 32'hAABB_0000) begin
         failures++; $display("FAIL rm_partial got=%h exp=aabb0000",
                              {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]});
      end
      cyc(); cyc();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid) seen = 1'b1;
         cyc();
      end
      checks++;
      if (seen !== 1'b0) begin failures++; $display("FAIL rm_no_rsp got=%b exp=0", seen); end
   endtask

   task automatic test_misalign();
      mem[8'h00] = 8'h01; mem[8'h01] = 8'h02; mem[8'h02] = 8'h03; mem[8'h03] = 8'h04;
      mem[8'h04] = 8'h05; mem[8'h05] = 8'h06;
`ifdef DMEM_MISALIGN_CHK_EN
      sb.push_back('{rdata: 32'h0, err: 1'b1});
`else
      sb.push_back('{rdata: model_load(32'h102, 4), err: 1'b0});
`endif
      do_access(1'b0, 2'b10, 32'h0000_0102, 32'h0);
      e = sb.pop_front();
      checks++;
      if ({got_rsp, got_rdata, got_err} !== {1'b1, e.rdata, e.err}) begin
         failures++; $display("FAIL ma_rsp got=%b/%h/%b exp=1/%h/%b", got_rsp, got_rdata, got_err, e.rdata, e.err);
      end
`ifdef DMEM_MISALIGN_CHK_EN
      checks++;
      if (b_addr.size() !== 0 || lat !== 1) begin
         failures++; $display("FAIL ma_shape got=%0d beats/%0d exp=0/1", b_addr.size(), lat);
      end
`else
      checks++;
      if (b_addr.size() !== 4 || lat !== 5) begin
         failures++; $display("FAIL ma_shape got=%0d beats/%0d exp=4/5", b_addr.size(), lat);
      end
`endif
      checks++;
      if (post_rsp_valid !== 1'b0 || err !== 1'b0) begin
         failures++; $display("FAIL ma_pulse got=%b/%b exp=0/0", post_rsp_valid, err);
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_byte_store();
      test_wrap_half();
      test_size3();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      checks++;
      if (sb.size() !== 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
